// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - control-unit handshake bundle for the multi-cycle shifter
interface shift_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   operand;
  logic               flush;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  // Control unit side: issues requests, watches status and captures result.
  modport master (
    output start, op, shamt, operand, flush,
    input  ready, busy, done, result
  );

  // Shifter side.
  modport slave (
    input  start, op, shamt, operand, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - one-bit-per-clock SLL/SRL/SRA/ROTR sequencer for the execute stage
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  shift_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   shift_d;

  // Single-bit step of the latched operation applied to the work register.
  always_comb begin
    shift_d = work_q;
    unique case (op_q)
      OP_SLL:  shift_d = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_d = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  shift_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_ROTR: shift_d = {work_q[0], work_q[WIDTH-1:1]};
      default: shift_d = work_q;
    endcase
  end

  // Sequencer FSM with registered handshake outputs; result only moves on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      work_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q    <= op_e'(bus.op);
            work_q  <= bus.operand;
            cnt_q   <= bus.shamt;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.shamt == '0) begin
              // Zero shift completes immediately with the untouched operand.
              result_q <= bus.operand;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              state_q  <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (bus.flush) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            work_q <= shift_d;
            cnt_q  <= cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
              result_q <= shift_d;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Always one cycle; flush here lands in the same place.
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_sequencer_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_exp = 32'h0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: whole shift computed in one step from the operation's definition.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x,
                                            input logic [4:0] s);
    int n;
    n = int'(s);
    case (op)
      2'b00:   return x << n;
      2'b01:   return x >> n;
      2'b10:   return 32'($signed(x) >>> n);
      default: return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
    endcase
  endfunction

  // One request from an idle block; checks latency, hold behaviour and return to IDLE.
  task automatic run_req(input string nm, input logic [1:0] op, input logic [31:0] operand,
                         input logic [4:0] shamt, input logic [31:0] exp, input bit noisy);
    int lat;
    bit status_ok;
    bit stable_ok;
    lat = 0;
    status_ok = 1'b1;
    stable_ok = 1'b1;
    chk({nm, " ready_before"}, 32'(bus.ready), 32'd1);
    bus.op = op; bus.operand = operand; bus.shamt = shamt; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (noisy) begin
      bus.op = 2'($urandom); bus.operand = $urandom; bus.shamt = 5'($urandom);
    end
    while (bus.done !== 1'b1 && lat <= 40) begin
      if (bus.busy !== 1'b1 || bus.ready !== 1'b0) status_ok = 1'b0;
      if (bus.result !== last_exp) stable_ok = 1'b0;
      if (noisy) bus.start = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " done_seen"}, 32'(bus.done), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(shamt));
    chk({nm, " result"}, bus.result, exp);
    chk({nm, " status_while_shifting"}, 32'(status_ok), 32'd1);
    chk({nm, " result_held_while_shifting"}, 32'(stable_ok), 32'd1);
    chk({nm, " busy_at_done"}, 32'({bus.busy, bus.ready}), 32'b10);
    last_exp = exp;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, " idle_after"}, 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    chk({nm, " result_after"}, bus.result, exp);
  endtask

  initial begin
    int done_seen;
    vec_t v;
    logic [1:0]  rop;
    logic [31:0] rx;
    logic [4:0]  rs;

    vecs[0]  = '{2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004};
    vecs[1]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[2]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[3]  = '{2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F};
    vecs[4]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[5]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[6]  = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[7]  = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[8]  = '{2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[9]  = '{2'b11, 32'h0000_0001, 5'd31, 32'h0000_0002};
    vecs[10] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[11] = '{2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000};

    bus.start = 1'b0; bus.op = 2'b00; bus.shamt = '0; bus.operand = '0; bus.flush = 1'b0;

    // Reset for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    chk("reset_result", bus.result, 32'h0);
    rst = 1'b0;
    last_exp = 32'h0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      run_req($sformatf("vec%0d", i), v.op, v.operand, v.shamt, v.exp, 1'b0);
    end

    // Flush at cycle 5 of a 20-step SLL.
    bus.op = 2'b00; bus.operand = 32'h1234_5678; bus.shamt = 5'd20; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_idle", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    chk("flush_result_kept", bus.result, last_exp);
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.done === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", 32'(done_seen), 32'd0);

    // Flush while idle blocks a start.
    bus.flush = 1'b1; bus.start = 1'b1; bus.shamt = 5'd0; bus.operand = 32'hAAAA_5555;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    chk("flush_idle_no_accept", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    run_req("after_flush", 2'b00, 32'h0000_0003, 5'd1, 32'h0000_0006, 1'b0);

    // Reset mid-shift with an ignored second start.
    done_seen = 0;
    bus.op = 2'b01; bus.operand = 32'hF0F0_F0F0; bus.shamt = 5'd10; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.operand = 32'h1; bus.shamt = 5'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.done === 1'b1) done_seen++;
    @(posedge clk); #1;
    if (bus.done === 1'b1) done_seen++;
    chk("second_start_ignored", 32'({bus.ready, bus.busy, bus.done}), 32'b010);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midshift_reset_outputs", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    chk("midshift_reset_result", bus.result, 32'h0);
    last_exp = 32'h0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    chk("midshift_reset_no_done", 32'(done_seen), 32'd0);

    // Randomized back-to-back requests with noisy inputs while busy.
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom);
      rx  = $urandom;
      rs  = (i % 10 == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      run_req($sformatf("rand%0d", i), rop, rx, rs, ref_shift(rop, rx, rs), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
